// File: rtl/inst_sram_pkg.sv
// Shared encodings for the SRAM-like instruction bus responder: FSM states,
// queue entry layout and transfer-size codes.
package inst_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } resp_state_e;

    localparam int WR_W     = 1;
    localparam int SIZE_W   = 2;
    localparam int WSTRB_W  = 4;
    localparam int WDATA_OFF = 0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Entry is packed MSB-first as {wr, size, wstrb, addr, wdata}.
    function automatic int entry_width(input int addr_w, input int data_w);
        return WR_W + SIZE_W + WSTRB_W + addr_w + data_w;
    endfunction

    function automatic int addr_off(input int data_w);
        return WDATA_OFF + data_w;
    endfunction

    function automatic int wstrb_off(input int addr_w, input int data_w);
        return addr_off(data_w) + addr_w;
    endfunction

    function automatic int size_off(input int addr_w, input int data_w);
        return wstrb_off(addr_w, data_w) + WSTRB_W;
    endfunction

    function automatic int wr_off(input int addr_w, input int data_w);
        return size_off(addr_w, data_w) + SIZE_W;
    endfunction

endpackage

// File: rtl/inst_sram_like_responder_fifo.sv
// resp_req_fifo: generic DEPTH x W synchronous FIFO with a combinational head,
// used as the outstanding-request queue of the responder.
module resp_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_sram_like_responder.sv
// Responder end of the SRAM-like instruction bus: queues requests and serves them
// in order from a 1-cycle synchronous memory. Optional: INST_SRAM_RESP_RANDOM_DELAY_EN.
module inst_sram_like_responder
    import inst_sram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int DELAY  = 0,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_sram_req_i,
    input  logic              inst_sram_wr_i,
    input  logic [1:0]        inst_sram_size_i,
    input  logic [3:0]        inst_sram_wstrb_i,
    input  logic [ADDR_W-1:0] inst_sram_addr_i,
    input  logic [DATA_W-1:0] inst_sram_wdata_i,
    output logic              inst_sram_addr_ok_o,
    output logic              inst_sram_data_ok_o,
    output logic [DATA_W-1:0] inst_sram_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        dbg_state_o
);

    localparam int EW        = entry_width(ADDR_W, DATA_W);
    localparam int ADDR_OFF  = addr_off(DATA_W);
    localparam int WSTRB_OFF = wstrb_off(ADDR_W, DATA_W);
    localparam int SIZE_OFF  = size_off(ADDR_W, DATA_W);
    localparam int WR_OFF    = wr_off(ADDR_W, DATA_W);
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int DW        = $clog2(DELAY + 4) + 1;

    resp_state_e       state;
    logic [DW-1:0]     dcnt;
    logic [DW-1:0]     eff_delay;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              push_req;
    logic              pop_req;
    logic              have_work;
    logic              head_wr;
    logic [1:0]        head_size;
    logic [3:0]        head_wstrb;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              unused_ok;

    // Handshake: a request transfers on any cycle where req_i and addr_ok_o are
    // both 1; addr_ok_o depends only on queue occupancy, never on req_i. Each
    // transfer earns exactly one data_ok_o pulse, in transfer order.
    assign inst_sram_addr_ok_o = !full;
    assign push_req   = inst_sram_req_i && inst_sram_addr_ok_o;
    assign pop_req    = (state == ST_RESP);
    assign push_entry = {inst_sram_wr_i, inst_sram_size_i, inst_sram_wstrb_i,
                         inst_sram_addr_i, inst_sram_wdata_i};

    resp_req_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop_req),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign head_wr    = head[WR_OFF];
    assign head_size  = head[SIZE_OFF +: SIZE_W];
    assign head_wstrb = head[WSTRB_OFF +: WSTRB_W];
    assign head_addr  = head[ADDR_OFF +: ADDR_W];
    assign head_wdata = head[WDATA_OFF +: DATA_W];
    assign unused_ok  = ^{head_size, head_addr[1:0], head_addr[ADDR_W-1:MEM_AW+2]};

`ifdef INST_SRAM_RESP_RANDOM_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign eff_delay = DW'(DELAY) + DW'(lfsr[1:0]);
`else
    assign eff_delay = DW'(DELAY);
`endif

    // In RESP the head is leaving, so work remains only if another entry is
    // queued behind it or one is arriving on this same edge.
    assign have_work = (state == ST_RESP) ? ((count > CW'(1)) || push_req) : !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (have_work) begin
                        if (eff_delay != '0) begin
                            state <= ST_WAIT;
                            dcnt  <= eff_delay - DW'(1);
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dcnt == '0) state <= ST_ISSUE;
                    else            dcnt  <= dcnt - DW'(1);
                end
                ST_ISSUE: state <= ST_RESP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign mem_en_o            = (state == ST_ISSUE);
    assign mem_we_o            = (state == ST_ISSUE && head_wr) ? head_wstrb : 4'b0000;
    assign mem_addr_o          = head_addr[MEM_AW+1:2];
    assign mem_wdata_o         = head_wdata;
    assign inst_sram_data_ok_o = (state == ST_RESP);
    assign inst_sram_rdata_o   = (state == ST_RESP && !head_wr) ? mem_rdata_i : '0;
    assign dbg_state_o         = state;

endmodule

// File: tb/tb_inst_sram_like_responder.sv
// Self-checking bench for inst_sram_like_responder: behavioural request queue and
// reference memory, directed cases with literal expectations, then random traffic.
module tb_inst_sram_like_responder;
    import inst_sram_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAW   = 14;
    localparam int DEPTH = 2;
    localparam int DELAY = 0;
`ifdef INST_SRAM_RESP_RANDOM_DELAY_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- main DUT (DELAY=0) ----------------
    logic          req = 1'b0, wr = 1'b0;
    logic [1:0]    size = 2'd0;
    logic [3:0]    wstrb = 4'd0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          addr_ok, data_ok, mem_en;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [3:0]    mem_we;
    logic [MAW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    inst_sram_like_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DELAY(DELAY), .MEM_AW(MAW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .inst_sram_req_i(req), .inst_sram_wr_i(wr), .inst_sram_size_i(size),
        .inst_sram_wstrb_i(wstrb), .inst_sram_addr_i(addr), .inst_sram_wdata_i(wdata),
        .inst_sram_addr_ok_o(addr_ok), .inst_sram_data_ok_o(data_ok), .inst_sram_rdata_o(rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .dbg_state_o(dbg_state)
    );

    // Environment RAM driven by the DUT's memory port.
    logic [31:0] ram [0:(1<<MAW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- second DUT (DELAY=3) for mid-operation reset ----------------
    logic          r3_rst_n = 1'b0, r3_req = 1'b0;
    logic          r3_wr = 1'b0;
    logic [1:0]    r3_size = 2'd2;
    logic [3:0]    r3_wstrb = 4'd0;
    logic [AW-1:0] r3_addr = '0;
    logic [DW-1:0] r3_wdata = '0;
    logic [DW-1:0] r3_mem_rdata = 32'hC0FF_EE00;
    logic          r3_addr_ok, r3_data_ok, r3_mem_en;
    logic [DW-1:0] r3_rdata, r3_mem_wdata;
    logic [3:0]    r3_mem_we;
    logic [MAW-1:0] r3_mem_addr;
    logic [1:0]    r3_state;
    int            n3_dok = 0, n3_men = 0;

    inst_sram_like_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DELAY(3), .MEM_AW(MAW)) u_dut_d3 (
        .clk(clk), .rst_n(r3_rst_n),
        .inst_sram_req_i(r3_req), .inst_sram_wr_i(r3_wr), .inst_sram_size_i(r3_size),
        .inst_sram_wstrb_i(r3_wstrb), .inst_sram_addr_i(r3_addr), .inst_sram_wdata_i(r3_wdata),
        .inst_sram_addr_ok_o(r3_addr_ok), .inst_sram_data_ok_o(r3_data_ok), .inst_sram_rdata_o(r3_rdata),
        .mem_en_o(r3_mem_en), .mem_we_o(r3_mem_we), .mem_addr_o(r3_mem_addr), .mem_wdata_o(r3_mem_wdata),
        .mem_rdata_i(r3_mem_rdata), .dbg_state_o(r3_state)
    );

    always @(negedge clk) begin
        if (r3_rst_n) begin
            if (r3_data_ok) n3_dok++;
            if (r3_mem_en)  n3_men++;
        end
    end

    // ---------------- scoreboard / behavioural model ----------------
    typedef struct {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
    } req_t;
    typedef struct {
        int          cyc;
        logic [31:0] val;
    } log_t;

    req_t        exp_q[$];
    log_t        resp_log[$];
    log_t        issue_log[$];
    logic [31:0] ref_mem [0:(1<<MAW)-1];
    bit          mon_en = 1'b0;
    bit          issued = 1'b0;
    int          issue_cyc = 0;
    int          prev_resp = -100;
    int          mon_lo = 0;
    int          n_acc = 0, n_resp = 0;
    logic [31:0] exp_rdata = '0;
    int          errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0000_1357;
    endfunction

    // Timing rule: a head accepted after the previous response finished starts
    // DELAY+2 cycles after it was seen; otherwise DELAY+1 after that response.
    always @(negedge clk) begin
        if (mon_en) begin
            check("addr_ok", addr_ok, 32'(exp_q.size() != DEPTH));
            check("data_ok", data_ok, 32'(issued && cyc == issue_cyc + 1));
            if (data_ok && issued && cyc == issue_cyc + 1) begin
                check("rdata", rdata, exp_rdata);
                resp_log.push_back('{cyc, rdata});
                void'(exp_q.pop_front());
                prev_resp = cyc;
                issued = 1'b0;
                n_resp++;
            end
            if (exp_q.size() != 0 && !issued) begin
                mon_lo = (exp_q[0].acc <= prev_resp) ? prev_resp + 1 + DELAY : exp_q[0].acc + 2 + DELAY;
                if (mem_en) begin
                    check("mem_en_cycle", 32'(cyc), (cyc >= mon_lo && cyc <= mon_lo + EXTRA) ? 32'(cyc) : 32'(mon_lo));
                    check("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr[MAW+1:2]));
                    check("mem_we", 32'(mem_we), exp_q[0].wr ? 32'(exp_q[0].wstrb) : 32'd0);
                    if (exp_q[0].wr) check("mem_wdata", mem_wdata, exp_q[0].wdata);
                    exp_rdata = exp_q[0].wr ? 32'd0 : ref_mem[exp_q[0].addr[MAW+1:2]];
                    if (exp_q[0].wr)
                        for (int b = 0; b < 4; b++)
                            if (exp_q[0].wstrb[b])
                                ref_mem[exp_q[0].addr[MAW+1:2]][b*8 +: 8] = exp_q[0].wdata[b*8 +: 8];
                    issued = 1'b1;
                    issue_cyc = cyc;
                    issue_log.push_back('{cyc, 32'(mem_addr)});
                end else if (cyc == mon_lo + EXTRA) begin
                    check("mem_en_late", 32'(mem_en), 32'd1);
                end
            end else begin
                check("mem_en_idle", 32'(mem_en), 32'd0);
            end
            if (req && addr_ok) begin
                exp_q.push_back('{wr, wstrb, addr, wdata, cyc});
                n_acc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int stalls, output int acc);
        int  n;
        bit  got;
        req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d; size = SIZE_WORD;
        n = 0; stalls = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (addr_ok) got = 1'b1;
            else         stalls++;
        end
        acc = cyc;
        if (!got) check("send_timeout", 32'(addr_ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0; wr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_logs();
        resp_log.delete();
        issue_log.delete();
    endtask

    // ---------------- stimulus ----------------
    int st, acc0, acc1, acc2, lat, dummy;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < (1<<MAW); i++) begin
            ram[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        ram[4] = 32'h1234_5678;  ref_mem[4] = 32'h1234_5678;
        ram[0] = 32'hA0A0_0000;  ref_mem[0] = 32'hA0A0_0000;
        ram[1] = 32'hA1A1_1111;  ref_mem[1] = 32'hA1A1_1111;
        ram[2] = 32'hA2A2_2222;  ref_mem[2] = 32'hA2A2_2222;
        ram[8] = 32'hFFFF_FFFF;  ref_mem[8] = 32'hFFFF_FFFF;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_ok", 32'(addr_ok), 32'd1);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Single read of word 4
        clear_logs();
        send(1'b0, 4'h0, 32'h10, 32'h0, st, acc0);
        idle(1);
        drain();
        check("single_resp_count", 32'(resp_log.size()), 32'd1);
        if (resp_log.size() == 1 && issue_log.size() == 1) begin
            lat = issue_log[0].cyc - acc0;
            check("single_issue_lat", 32'(lat), (lat >= 2 && lat <= 2 + EXTRA) ? 32'(lat) : 32'd2);
            check("single_mem_addr", issue_log[0].val, 32'd4);
            check("single_resp_lat", 32'(resp_log[0].cyc - issue_log[0].cyc), 32'd1);
            check("single_rdata", resp_log[0].val, 32'h1234_5678);
        end

        // Fill the queue with req held high
        clear_logs();
        send(1'b0, 4'h0, 32'h0, 32'h0, st, acc0);
        send(1'b0, 4'h0, 32'h4, 32'h0, st, acc1);
        check("fill_second_no_stall", 32'(st), 32'd0);
        send(1'b0, 4'h0, 32'h8, 32'h0, st, acc2);
        idle(1);
        drain();
        check("fill_resp_count", 32'(resp_log.size()), 32'd3);
        if (resp_log.size() == 3) begin
            check("fill_acc_after_dok", 32'(acc2), 32'(resp_log[0].cyc + 1));
            check("fill_stall_cycles", 32'(st), 32'(resp_log[0].cyc + 1 - (acc1 + 1)));
            check("fill_rdata0", resp_log[0].val, 32'hA0A0_0000);
            check("fill_rdata1", resp_log[1].val, 32'hA1A1_1111);
            check("fill_rdata2", resp_log[2].val, 32'hA2A2_2222);
        end

        // Write with partial strobes then read back
        clear_logs();
        send(1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF, st, acc0);
        send(1'b0, 4'h0, 32'h20, 32'h0, st, acc1);
        idle(1);
        drain();
        check("wr_resp_count", 32'(resp_log.size()), 32'd2);
        if (resp_log.size() == 2) begin
            check("wr_rdata_zero", resp_log[0].val, 32'h0);
            check("rd_after_wr", resp_log[1].val, 32'hFFFF_BEEF);
        end

        // Master flushes and ignores responses: still exactly two data_ok
        clear_logs();
        send(1'b0, 4'h0, 32'h40, 32'h0, st, acc0);
        send(1'b0, 4'h0, 32'h44, 32'h0, st, acc1);
        idle(1);
        drain();
        idle(6);
        check("flush_resp_count", 32'(resp_log.size()), 32'd2);
        check("flush_addr_ok", 32'(addr_ok), 32'd1);
        check("flush_state_idle", 32'(dbg_state), 32'(ST_IDLE));

        // 16 back-to-back reads, then random mixed traffic over a small window
        for (int i = 0; i < 16; i++)
            send(1'b0, 4'h0, 32'(i) << 2, 32'h0, st, dummy);
        idle(1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            ra = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(16, 31)) << 2);
            send($urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)), ra, $urandom, st, dummy);
        end
        idle(1);
        drain();
        check("acc_equals_resp", 32'(n_resp), 32'(n_acc));

        // Mid-operation reset on the DELAY=3 instance
        @(posedge clk);
        #1;
        r3_rst_n = 1'b1;
        @(posedge clk);
        #1;
        r3_req = 1'b1; r3_addr = 32'h0;
        @(negedge clk);
        check("d3_acc0", 32'(r3_addr_ok), 32'd1);
        @(posedge clk);
        #1;
        r3_addr = 32'h4;
        @(negedge clk);
        check("d3_acc1", 32'(r3_addr_ok), 32'd1);
        @(posedge clk);
        #1;
        r3_req = 1'b0;
        for (int n = 0; n < 20 && r3_state != 2'(ST_WAIT); n++) @(posedge clk);
        #1;
        check("d3_in_wait", 32'(r3_state), 32'(ST_WAIT));
        check("d3_full", 32'(r3_addr_ok), 32'd0);
        check("d3_no_dok_yet", 32'(n3_dok), 32'd0);
        r3_rst_n = 1'b0;
        #1;
        check("d3_rst_addr_ok", 32'(r3_addr_ok), 32'd1);
        check("d3_rst_state", 32'(r3_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        r3_rst_n = 1'b1;
        n3_dok = 0; n3_men = 0;
        repeat (12) @(posedge clk);
        #1;
        check("d3_post_rst_dok", 32'(n3_dok), 32'd0);
        check("d3_post_rst_men", 32'(n3_men), 32'd0);
        check("d3_post_rst_addr_ok", 32'(r3_addr_ok), 32'd1);
        r3_req = 1'b1; r3_addr = 32'h8;
        @(negedge clk);
        check("d3_new_acc", 32'(r3_addr_ok), 32'd1);
        @(posedge clk);
        #1;
        r3_req = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("d3_new_dok", 32'(n3_dok), 32'd1);
        check("d3_new_men", 32'(n3_men), 32'd1);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
